// File: rtl/scc68070_bus_responder.sv
// Target-side SCC68070 bus responder: one backing-memory transaction per CPU access, ack pulse, watchdog.
// Optional bus-error timeout is compiled in with `define SCC_BUS_TIMEOUT_EN.
module scc68070_bus_responder #(
   parameter int unsigned MIN_WAIT = 1,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        as,
   input  logic        lds,
   input  logic        uds,
   input  logic        write_strobe,
   input  logic [22:0] addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        bus_ack,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_be,
   output logic [22:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata
);

   localparam int unsigned CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   // wait_cnt saturates at TIMEOUT, so the ack threshold must never exceed it
   localparam int unsigned WAIT_TGT = (MIN_WAIT + 1 > TIMEOUT) ? TIMEOUT : MIN_WAIT + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(WAIT_TGT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DRAIN} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             done;
   logic             pending;
   logic             ready_c;
   logic             done_c;

   // only a response to our own outstanding request counts
   assign ready_c = mem_ready && pending;
   assign done_c  = done || ready_c;

`ifdef SCC_BUS_TIMEOUT_EN
   logic [CNT_W-1:0] tmo_cnt;
`else
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         done      <= 1'b0;
         pending   <= 1'b0;
         cpu_rdata <= 16'h0000;
         bus_ack   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 2'b00;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef SCC_BUS_TIMEOUT_EN
         tmo_cnt   <= '0;
         bus_err   <= 1'b0;
`endif
      end else begin
         mem_req <= 1'b0;
         bus_ack <= 1'b0;
`ifdef SCC_BUS_TIMEOUT_EN
         bus_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (as) begin
                  mem_addr  <= addr;
                  mem_we    <= write_strobe;
                  mem_wdata <= cpu_wdata;
                  wait_cnt  <= '0;
`ifdef SCC_BUS_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
                  // a write with no strobes completes without touching memory
                  if (write_strobe && !lds && !uds) begin
                     mem_be  <= 2'b00;
                     done    <= 1'b1;
                     pending <= 1'b0;
                  end else begin
                     mem_be  <= (lds || uds) ? {uds, lds} : 2'b11;
                     mem_req <= 1'b1;
                     done    <= 1'b0;
                     pending <= 1'b1;
                  end
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
`ifdef SCC_BUS_TIMEOUT_EN
               if (tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
               if (ready_c) begin
                  pending <= 1'b0;
                  done    <= 1'b1;
               end
               if (!as) begin
                  state <= (pending && !mem_ready) ? S_DRAIN : S_IDLE;
               end else begin
                  if (ready_c && !mem_we) cpu_rdata <= mem_rdata;
                  if (done_c && wait_cnt >= CNT_TGT) begin
                     bus_ack <= 1'b1;
                     state   <= S_ACK;
                  end
`ifdef SCC_BUS_TIMEOUT_EN
                  else if (!done_c && tmo_cnt == CNT_MAX) begin
                     bus_ack   <= 1'b1;
                     bus_err   <= 1'b1;
                     cpu_rdata <= 16'hFFFF;
                     state     <= S_ACK;
                  end
`endif
               end
            end
            S_ACK: begin
               // a timed-out request may still be outstanding here
               if (mem_ready) pending <= 1'b0;
               state <= (pending && !mem_ready) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
               if (mem_ready) begin
                  pending <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scc68070_bus_responder.sv
// Self-checking bench for scc68070_bus_responder: vector table plus abort/reset/back-to-back/timeout sequences.
module tb_scc68070_bus_responder;

   localparam int MW  = 3;
   localparam int TMO = 16;
   localparam int NV  = 14;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        as = 1'b0, lds = 1'b0, uds = 1'b0, write_strobe = 1'b0;
   logic [22:0] addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        bus_ack, bus_err, mem_req, mem_we;
   logic [1:0]  mem_be;
   logic [22:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_rdata = '0;

   scc68070_bus_responder #(.MIN_WAIT(MW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .as(as), .lds(lds), .uds(uds),
      .write_strobe(write_strobe), .addr(addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  be;
      logic [22:0] a;
      logic [15:0] wd;
      logic [15:0] rd;
      int          rdy;
      logic        exp_req;
      logic [1:0]  exp_be;
      int          exp_lat;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t        tbl [NV];
   int          n_vec = 0, n_bad = 0;
   logic [15:0] model_rd = 16'h0000;

   int          req_n, ack_n, req_cnt;
   logic        err_q, err_any, we_q;
   logic [15:0] rdat_q, wd_q;
   logic [1:0]  be_q;
   logic [22:0] addr_q;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // latency in edges from the request edge to the ack edge, from the timing rules alone
   function automatic int ack_after_req(input int rdy);
      return imax(rdy + 1, MW + 2);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Observe one transaction at negedges; the memory model answers rdy negedges after mem_req.
   task automatic run(input int rdy, input logic [15:0] rd, input int budget, input bit drop);
      int rdy_at;
      rdy_at = -1; req_n = -1; ack_n = -1; req_cnt = 0; err_any = 1'b0;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         mem_rdata = 16'($urandom);
         err_any   = err_any | bus_err;
         if (mem_req) begin
            req_cnt++;
            if (req_n < 0) begin
               req_n = n; we_q = mem_we; be_q = mem_be; addr_q = mem_addr; wd_q = mem_wdata;
               rdy_at = n + rdy;
            end
         end
         if (bus_ack) begin
            ack_n = n; err_q = bus_err; rdat_q = cpu_rdata;
            if (drop) as = 1'b0;
            break;
         end
         if (n == rdy_at) begin
            mem_ready = 1'b1;
            mem_rdata = rd;
         end
      end
   endtask

   task automatic start(input logic we, input logic [1:0] be, input logic [22:0] a, input logic [15:0] wd);
      @(negedge clk);
      as = 1'b1; write_strobe = we; {uds, lds} = be; addr = a; cpu_wdata = wd;
   endtask

   // Fresh word read from IDLE with full checking.
   task automatic fresh_read(input logic [22:0] a, input string tag);
      logic [15:0] rd;
      int          rdy;
      rd = 16'($urandom); rdy = $urandom_range(0, 4);
      start(1'b0, 2'b11, a, 16'h0);
      run(rdy, rd, 40, 1'b1);
      check({tag, "_req_n"}, 32'(req_n), 32'd1);
      check({tag, "_lat"}, 32'(ack_n - req_n), 32'(ack_after_req(rdy)));
      check({tag, "_rdata"}, {16'h0, rdat_q}, {16'h0, rd});
      model_rd = rd;
      @(negedge clk);
      check({tag, "_ack_pulse"}, {31'h0, bus_ack}, 32'h0);
   endtask

   initial begin
      // table: two directed cases, one strobe-less write, the rest random
      tbl[0] = '{we:1'b0, be:2'b00, a:23'h000100, wd:16'h0, rd:16'hBEEF, rdy:1,
                 exp_req:1'b0, exp_be:2'b00, exp_lat:0, exp_rdata:16'h0};
      tbl[1] = '{we:1'b1, be:2'b10, a:23'h7FFFFF, wd:16'h5A00, rd:16'h0, rdy:0,
                 exp_req:1'b0, exp_be:2'b00, exp_lat:0, exp_rdata:16'h0};
      tbl[2] = '{we:1'b1, be:2'b00, a:23'h012345, wd:16'h1234, rd:16'h0, rdy:0,
                 exp_req:1'b0, exp_be:2'b00, exp_lat:0, exp_rdata:16'h0};
      for (int i = 3; i < NV; i++) begin
         tbl[i].we  = 1'($urandom);
         tbl[i].be  = 2'($urandom);
         tbl[i].a   = 23'($urandom);
         tbl[i].wd  = 16'($urandom);
         tbl[i].rd  = 16'($urandom);
         tbl[i].rdy = $urandom_range(0, 8);
      end
      begin
         logic [15:0] m;
         m = 16'h0000;
         for (int i = 0; i < NV; i++) begin
            tbl[i].exp_req   = !(tbl[i].we && tbl[i].be == 2'b00);
            tbl[i].exp_be    = (tbl[i].be == 2'b00) ? 2'b11 : tbl[i].be;
            tbl[i].exp_lat   = tbl[i].exp_req ? ack_after_req(tbl[i].rdy) : MW + 2;
            if (!tbl[i].we) m = tbl[i].rd;
            tbl[i].exp_rdata = m;
         end
      end

      repeat (3) @(negedge clk);
      check("reset_outputs", {cpu_rdata, bus_ack, bus_err, mem_req, mem_we, mem_be, 7'h0},
            32'h0);
      check("reset_addr_wdata", {1'b0, mem_addr, 8'h0} | {16'h0, mem_wdata}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         start(tbl[i].we, tbl[i].be, tbl[i].a, tbl[i].wd);
         run(tbl[i].rdy, tbl[i].rd, 40, 1'b1);
         check($sformatf("v%0d_lat", i), 32'(ack_n - 1), 32'(tbl[i].exp_lat));
         check($sformatf("v%0d_reqcnt", i), 32'(req_cnt), {31'h0, tbl[i].exp_req});
         if (tbl[i].exp_req) begin
            check($sformatf("v%0d_req_n", i), 32'(req_n), 32'd1);
            check($sformatf("v%0d_we_be", i), {29'h0, we_q, be_q}, {29'h0, tbl[i].we, tbl[i].exp_be});
            check($sformatf("v%0d_addr", i), {9'h0, addr_q}, {9'h0, tbl[i].a});
            if (tbl[i].we) check($sformatf("v%0d_wdata", i), {16'h0, wd_q}, {16'h0, tbl[i].wd});
         end
         check($sformatf("v%0d_rdata", i), {16'h0, rdat_q}, {16'h0, tbl[i].exp_rdata});
         check($sformatf("v%0d_err", i), {31'h0, err_q}, 32'h0);
         @(negedge clk);
         check($sformatf("v%0d_ack_pulse", i), {31'h0, bus_ack}, 32'h0);
      end
      model_rd = tbl[NV-1].exp_rdata;

      // back-to-back: as held across three reads of one address
      start(1'b0, 2'b11, 23'h00ABCD, 16'h0);
      for (int j = 0; j < 3; j++) begin
         logic [15:0] rd;
         int          rdy;
         rd = 16'($urandom); rdy = $urandom_range(0, 3);
         run(rdy, rd, 40, j == 2);
         check($sformatf("b2b%0d_reqcnt", j), 32'(req_cnt), 32'd1);
         check($sformatf("b2b%0d_lat", j), 32'(ack_n - req_n), 32'(ack_after_req(rdy)));
         check($sformatf("b2b%0d_rdata", j), {16'h0, rdat_q}, {16'h0, rd});
         @(negedge clk);
         check($sformatf("b2b%0d_no_consec_ack", j), {30'h0, bus_ack, mem_req}, 32'h0);
         model_rd = rd;
      end

      // abort: as dropped in WAIT, response arrives 4 cycles later and is discarded
      start(1'b0, 2'b01, 23'h004242, 16'h0);
      @(negedge clk);
      check("abort_req", {31'h0, mem_req}, 32'h1);
      @(negedge clk);
      as = 1'b0;
      @(negedge clk);
      as = 1'b1; addr = 23'h006161; {uds, lds} = 2'b11;
      for (int n = 4; n <= 7; n++) begin
         @(negedge clk);
         mem_ready = (n == 6);
         mem_rdata = 16'hDEAD;
         check($sformatf("abort_quiet%0d", n), {30'h0, bus_ack, mem_req}, 32'h0);
      end
      mem_ready = 1'b0;
      begin
         logic [15:0] rd;
         rd = 16'h1357;
         run(2, rd, 40, 1'b1);
         check("abort_next_req_n", 32'(req_n), 32'd1);
         check("abort_next_addr", {9'h0, addr_q}, {9'h0, 23'h006161});
         check("abort_next_lat", 32'(ack_n - req_n), 32'(ack_after_req(2)));
         check("abort_next_rdata", {16'h0, rdat_q}, {16'h0, rd});
         model_rd = rd;
         @(negedge clk);
      end

      // asynchronous reset in the middle of WAIT
      start(1'b0, 2'b11, 23'h0155AA, 16'h0);
      @(negedge clk);
      check("rst_pre_addr", {9'h0, mem_addr}, {9'h0, 23'h0155AA});
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_async_outputs", {cpu_rdata, bus_ack, bus_err, mem_req, mem_we, mem_be, 7'h0},
            32'h0);
      check("rst_async_addr", {9'h0, mem_addr}, 32'h0);
      model_rd = 16'h0000;
      @(negedge clk);
      reset = 1'b0; as = 1'b0;
      @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      check("rst_stale_ready", {30'h0, bus_ack, mem_req}, 32'h0);
      fresh_read(23'h000777, "rst_after");

      // watchdog
      start(1'b0, 2'b11, 23'h003000, 16'h0);
`ifdef SCC_BUS_TIMEOUT_EN
      run(100000, 16'h0, 40, 1'b1);
      check("tmo_lat", 32'(ack_n - req_n), 32'(TMO + 1));
      check("tmo_err", {31'h0, err_q}, 32'h1);
      check("tmo_rdata", {16'h0, rdat_q}, 32'h0000FFFF);
      @(negedge clk);
      check("tmo_pulse", {30'h0, bus_ack, bus_err}, 32'h0);
`else
      run(100000, 16'h0, 1000, 1'b0);
      check("notmo_no_ack", 32'(ack_n), 32'hFFFFFFFF);
      check("notmo_no_err", {31'h0, err_any}, 32'h0);
      as = 1'b0;
      @(negedge clk);
`endif
      // retire the abandoned request, then prove the bus still works
      @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      fresh_read(23'h003001, "tmo_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
